// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder
// Clocked keypad front end with four stages:
//   1. a two-flop synchroniser on the raw key lines,
//   2. a highest-index-wins priority encoder,
//   3. a press/release debounce FSM,
//   4. registered outputs: the accepted code, a level valid, and a one-cycle
//      strobe for each accepted press.
// A second key added while one is held is locked out; it never rolls over.
module keypad_debounce_encoder #(
  parameter int unsigned NUM_KEYS        = 10,
  parameter int unsigned CODE_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_n,
  input  logic [NUM_KEYS-1:0] keypad,
  output logic [CODE_W-1:0]   code_out,
  output logic                data_valid,
  output logic                key_pulse
);

  // One spare bit so the counter can never wrap before the FSM leaves the state.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  // Reject parameter sets the encoder or counter cannot represent.
  if (NUM_KEYS < 2) begin : g_bad_keys
    $error("keypad_debounce_encoder: NUM_KEYS must be >= 2");
  end
  if (CODE_W < $clog2(NUM_KEYS)) begin : g_bad_code_w
    $error("keypad_debounce_encoder: CODE_W too narrow for NUM_KEYS");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("keypad_debounce_encoder: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [CODE_W-1:0]   enc;
  logic                any;
  state_t              state;
  logic [CODE_W-1:0]   cand;
  logic [CNT_W-1:0]    cnt;

  // Two-flop synchroniser. It keeps running while disabled, so a re-enable
  // starts from an already-settled view of the keypad.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keypad;
      sync2 <= sync1;
    end
  end

  // Priority encoder: the highest set index wins, zero-extended to CODE_W.
  always_comb begin
    enc = '0;
    any = |sync2;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sync2[i]) begin
        enc = CODE_W'(i);
      end
    end
  end

  // Debounce FSM with registered outputs.
  // Disable takes synchronous priority over every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      code_out   <= '0;
      data_valid <= 1'b0;
      key_pulse  <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (enable_n) begin
        state      <= IDLE;
        cand       <= '0;
        cnt        <= '0;
        code_out   <= '0;
        data_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (any) begin
              cand  <= enc;
              cnt   <= CNT_ONE;
              state <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!any) begin
              cnt   <= '0;
              state <= IDLE;
            end else if (enc != cand) begin
              // A different key restarts the count with the new candidate.
              cand <= enc;
              cnt  <= CNT_ONE;
            end else if (cnt == CNT_LAST) begin
              state      <= PRESSED;
              code_out   <= cand;
              data_valid <= 1'b1;
              key_pulse  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          PRESSED: begin
            // Extra or different keys are ignored until a full release.
            if (!any) begin
              cnt   <= CNT_ONE;
              state <= RELEASE;
            end
          end
          RELEASE: begin
            if (any) begin
              // Release bounce: treat it as the same press, with no new pulse.
              state <= PRESSED;
            end else if (cnt == CNT_LAST) begin
              cnt        <= '0;
              data_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Testbench for keypad_debounce_encoder. Directed scenarios plus a random
// soak, all checked against a history-based reference model.
module tb_keypad_debounce_encoder;

  localparam int NK = 10;
  localparam int CW = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable_n;
  logic [NK-1:0] keypad;
  logic [CW-1:0] code_out;
  logic          data_valid;
  logic          key_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  keypad_debounce_encoder #(
    .NUM_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .enable_n(enable_n), .keypad(keypad),
    .code_out(code_out), .data_valid(data_valid), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  // Reference model. It tracks the delayed sample stream and the lengths of
  // runs of identical non-zero codes and of zeros; it does not track FSM state.
  logic [NK-1:0] m_k1, m_k2;
  int m_run_len, m_run_val, m_zero_run, m_code;
  bit m_held, m_pulse;

  function automatic int top_bit(input logic [NK-1:0] v);
    for (int i = NK - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [NK-1:0] s;
    if (reset) begin
      m_k1 = '0; m_k2 = '0; m_run_len = 0; m_run_val = 0; m_zero_run = 0;
      m_code = 0; m_held = 0; m_pulse = 0;
    end else begin
      s = m_k2; m_k2 = m_k1; m_k1 = keypad;
      m_pulse = 0;
      if (enable_n) begin
        m_held = 0; m_code = 0; m_run_len = 0; m_zero_run = 0;
      end else if (!m_held) begin
        if (s == '0) m_run_len = 0;
        else if (m_run_len > 0 && top_bit(s) == m_run_val) m_run_len++;
        else begin m_run_val = top_bit(s); m_run_len = 1; end
        if (m_run_len == DC) begin
          m_held = 1; m_code = m_run_val; m_pulse = 1; m_zero_run = 0;
        end
      end else begin
        if (s == '0) begin
          m_zero_run++;
          if (m_zero_run == DC) begin m_held = 0; m_run_len = 0; end
        end else m_zero_run = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({code_out, data_valid, key_pulse} !== {CW'(0), 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_init: got code=%0d dv=%b kp=%b, want 0/0/0", code_out, data_valid, key_pulse);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    enable_n = 1'b0; keypad = 10'b00_0000_1000;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if ({code_out, data_valid} !== {CW'(3), 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_pre: got code=%0d dv=%b, want 3/1", code_out, data_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({code_out, data_valid, key_pulse} !== {CW'(0), 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_async: got code=%0d dv=%b kp=%b, want 0/0/0", code_out, data_valid, key_pulse);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      pulses += int'(key_pulse);
      n_cmp++;
      if (data_valid !== (e >= 6) || (e == 6 && code_out !== CW'(3))) begin
        n_bad++;
        $display("FAIL reset_reaccept: edge %0d got dv=%b code=%0d, want dv=%b code=3", e, data_valid, code_out, e >= 6);
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL reset_reaccept_pulses: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_priority();
    do_reset();
    enable_n = 1'b0; keypad = 10'b10_0101_0101;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (e < 6 && {code_out, data_valid, key_pulse} !== {CW'(0), 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL priority_early: edge %0d got code=%0d dv=%b kp=%b, want 0/0/0", e, code_out, data_valid, key_pulse);
      end else if (e >= 6 && {code_out, data_valid, key_pulse} !== {CW'(9), 1'b1, e == 6}) begin
        n_bad++;
        $display("FAIL priority_accept: edge %0d got code=%0d dv=%b kp=%b, want 9/1/%0b", e, code_out, data_valid, key_pulse, e == 6);
      end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    do_reset();
    enable_n = 1'b0;
    for (int c = 0; c < 16; c++) begin
      keypad = (c < 2) ? 10'b00_0000_0100 : (c == 2) ? '0 : 10'b00_0000_0100;
      @(posedge clk); #1;
      pulses += int'(key_pulse);
      n_cmp++;
      if ({code_out, data_valid, key_pulse} !== {CW'(m_code), m_held, m_pulse}) begin
        n_bad++;
        $display("FAIL bounce_model: cyc %0d got %0d/%b/%b, want %0d/%b/%b", c, code_out, data_valid, key_pulse, m_code, m_held, m_pulse);
      end
    end
    n_cmp++;
    if (pulses != 1 || code_out !== CW'(2)) begin
      n_bad++;
      $display("FAIL bounce_result: got pulses=%0d code=%0d, want 1/2", pulses, code_out);
    end
  endtask

  task automatic test_disabled();
    int bad = 0;
    do_reset();
    enable_n = 1'b1; keypad = '1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if ({code_out, data_valid, key_pulse} !== {CW'(0), 1'b0, 1'b0}) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL disabled: got %0d cycles with nonzero outputs, want 0", bad);
    end
  endtask

  task automatic test_rollover();
    int pulses = 0;
    int waited = 0;
    do_reset();
    enable_n = 1'b0; keypad = 10'b00_0000_0010;
    while (!data_valid && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    n_cmp++;
    if (data_valid !== 1'b1 || code_out !== CW'(1)) begin
      n_bad++;
      $display("FAIL rollover_accept: got dv=%b code=%0d after %0d cycles, want 1/1", data_valid, code_out, waited);
    end
    keypad = 10'b01_0000_0010;
    repeat (8) begin @(posedge clk); #1; pulses += int'(key_pulse); end
    n_cmp++;
    if (pulses != 0 || code_out !== CW'(1) || data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rollover_lock: got pulses=%0d code=%0d dv=%b, want 0/1/1", pulses, code_out, data_valid);
    end
    keypad = '0;
    repeat (3) begin @(posedge clk); #1; pulses += int'(key_pulse); end
    keypad = 10'b00_0000_0010;
    repeat (6) begin @(posedge clk); #1; pulses += int'(key_pulse); end
    n_cmp++;
    if (pulses != 0 || data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL release_bounce: got pulses=%0d dv=%b, want 0/1", pulses, data_valid);
    end
    keypad = '0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (data_valid !== (e < 6) || code_out !== CW'(1) || key_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL release: edge %0d got dv=%b code=%0d kp=%b, want %b/1/0", e, data_valid, code_out, key_pulse, e < 6);
      end
    end
  endtask

  task automatic test_disable_press();
    int waited = 0;
    do_reset();
    enable_n = 1'b0; keypad = 10'b00_0010_0000;
    while (!data_valid && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    n_cmp++;
    if (code_out !== CW'(5) || data_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL dis_press_accept: got code=%0d dv=%b, want 5/1", code_out, data_valid);
    end
    enable_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({code_out, data_valid, key_pulse} !== {CW'(0), 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL dis_press_clear: got code=%0d dv=%b kp=%b, want 0/0/0", code_out, data_valid, key_pulse);
    end
    enable_n = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (data_valid !== (e >= DC) || key_pulse !== (e == DC) || (e >= DC && code_out !== CW'(5))) begin
        n_bad++;
        $display("FAIL dis_press_reaccept: edge %0d got dv=%b kp=%b code=%0d, want %b/%b/5", e, data_valid, key_pulse, code_out, e >= DC, e == DC);
      end
    end
  endtask

  task automatic test_random();
    logic [NK-1:0] pat;
    int len;
    int bad = 0;
    do_reset();
    for (int b = 0; b < 300; b++) begin
      case ($urandom_range(0, 3))
        0: pat = '0;
        1, 2: pat = NK'(1) << $urandom_range(0, NK - 1);
        default: pat = NK'($urandom);
      endcase
      keypad = pat;
      enable_n = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1; #1;
        n_cmp++;
        if ({code_out, data_valid, key_pulse} !== {CW'(0), 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL random_reset: got %0d/%b/%b, want 0/0/0", code_out, data_valid, key_pulse);
        end
        #1 reset = 1'b0;
      end
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        n_cmp++;
        if ({code_out, data_valid, key_pulse} !== {CW'(m_code), m_held, m_pulse}) begin
          n_bad++; bad++;
          if (bad <= 10)
            $display("FAIL random_model: burst %0d got %0d/%b/%b, want %0d/%b/%b", b, code_out, data_valid, key_pulse, m_code, m_held, m_pulse);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable_n = 1'b1; keypad = '0;
    test_reset();
    test_reset_mid();
    test_priority();
    test_bounce();
    test_disabled();
    test_rollover();
    test_disable_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
